// File: rtl/cond_logic_mc_if.sv
// Bus between the multicycle controller/ALU and the condition-check stage.
// The controller side (master) drives the raw strobes, Cond and ALU flags.
// The condition stage (slave) returns the committed strobes and the flag state.
interface cond_logic_mc_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       CondLatch;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC, RegW, MemW, NoWrite,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC, RegW, MemW, NoWrite,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx
  );
endinterface

// File: rtl/cond_logic_mc.sv
// Condition-check stage for the multicycle ARM datapath.
// Holds NZCV, decides the condition once per instruction (latched in DECODE)
// and gates the controller's raw write strobes with that held decision.
module cond_logic_mc #(
  parameter logic [3:0] FLAG_RESET  = 4'b0000,
  parameter bit         NV_EXECUTES = 1'b0
) (
  input logic           clk,
  input logic           reset,
  cond_logic_mc_if.slave bus
);

  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic       cond_ex_reg;
  logic       cond_ok;

  logic n_flag, z_flag, c_flag, v_flag;
  assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

  // Evaluate the condition from the registered flags only (never ALUFlags).
  always_comb begin
    cond_ok = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ok = z_flag;
      4'b0001: cond_ok = ~z_flag;
      4'b0010: cond_ok = c_flag;
      4'b0011: cond_ok = ~c_flag;
      4'b0100: cond_ok = n_flag;
      4'b0101: cond_ok = ~n_flag;
      4'b0110: cond_ok = v_flag;
      4'b0111: cond_ok = ~v_flag;
      4'b1000: cond_ok = c_flag & ~z_flag;
      4'b1001: cond_ok = ~c_flag | z_flag;
      4'b1010: cond_ok = (n_flag == v_flag);
      4'b1011: cond_ok = (n_flag != v_flag);
      4'b1100: cond_ok = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_ok = z_flag | (n_flag != v_flag);
      4'b1110: cond_ok = 1'b1;
      4'b1111: cond_ok = NV_EXECUTES;
      default: cond_ok = 1'b0;
    endcase
  end

  // Flag pairs are written independently: pair 0 is {C,V} under FlagW[0],
  // pair 1 is {N,Z} under FlagW[1]. The write uses the held (old) decision,
  // so a same-cycle CondLatch cannot affect it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      assign flags_next[2*gi +: 2] = (bus.FlagW[gi] & cond_ex_reg)
                                     ? bus.ALUFlags[2*gi +: 2]
                                     : flags_reg[2*gi +: 2];
    end
  endgenerate

  // Architectural flag register.
  always_ff @(posedge clk) begin
    if (reset) flags_reg <= FLAG_RESET;
    else       flags_reg <= flags_next;
  end

  // Held condition decision: loads only when the controller pulses CondLatch.
  always_ff @(posedge clk) begin
    if (reset)              cond_ex_reg <= 1'b0;
    else if (bus.CondLatch) cond_ex_reg <= cond_ok;
  end

  // Committed strobes; all forced low during reset so nothing partially commits.
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWrite = 1'b0;
    if (!reset) begin
      bus.PCWrite  = (bus.PCS & cond_ex_reg) | bus.NextPC;
      bus.RegWrite = bus.RegW & cond_ex_reg & ~bus.NoWrite;
      bus.MemWrite = bus.MemW & cond_ex_reg;
    end
  end

  assign bus.Flags  = flags_reg;
  assign bus.CondEx = cond_ex_reg;

endmodule

// File: tb/tb_cond_logic_mc.sv
// Directed bench for cond_logic_mc: two instances (NV never / NV executes)
// share the same stimulus; expected values are hand-derived constants or a
// small reference condition table.
module tb_cond_logic_mc;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_w;
  logic cond_latch, pcs, next_pc, reg_w, mem_w, no_write;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cond_logic_mc_if bus0 ();
  cond_logic_mc_if bus1 ();

  assign bus0.Cond = cond;       assign bus1.Cond = cond;
  assign bus0.ALUFlags = alu_flags; assign bus1.ALUFlags = alu_flags;
  assign bus0.FlagW = flag_w;    assign bus1.FlagW = flag_w;
  assign bus0.CondLatch = cond_latch; assign bus1.CondLatch = cond_latch;
  assign bus0.PCS = pcs;         assign bus1.PCS = pcs;
  assign bus0.NextPC = next_pc;  assign bus1.NextPC = next_pc;
  assign bus0.RegW = reg_w;      assign bus1.RegW = reg_w;
  assign bus0.MemW = mem_w;      assign bus1.MemW = mem_w;
  assign bus0.NoWrite = no_write; assign bus1.NoWrite = no_write;

  cond_logic_mc #(.FLAG_RESET(4'b0000), .NV_EXECUTES(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  cond_logic_mc #(.FLAG_RESET(4'b0000), .NV_EXECUTES(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: pairs of conditions share a base test, odd codes invert it.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f, input logic nv);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1110) return 1'b1;
    if (c == 4'b1111) return nv;
    return c[0] ? !base : base;
  endfunction

  task automatic latch(input logic [3:0] c);
    cond = c; cond_latch = 1'b1;
    tick();
    cond_latch = 1'b0;
  endtask

  task automatic write_flags(input logic [1:0] fw, input logic [3:0] af);
    flag_w = fw; alu_flags = af;
    tick();
    flag_w = 2'b00;
  endtask

  initial begin
    reset = 1'b1; cond = 4'b0; alu_flags = 4'b0; flag_w = 2'b0;
    cond_latch = 1'b0; no_write = 1'b0;
    pcs = 1'b1; next_pc = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
    #1;
    // 1: strobes low under reset regardless of raw requests
    check("rst_pcwrite", {3'b0, bus0.PCWrite}, 4'b0000);
    check("rst_regwrite", {3'b0, bus0.RegWrite}, 4'b0000);
    check("rst_memwrite", {3'b0, bus0.MemWrite}, 4'b0000);
    tick();
    check("rst_flags", bus0.Flags, 4'b0000);
    check("rst_condex", {3'b0, bus0.CondEx}, 4'b0000);
    reset = 1'b0; pcs = 1'b0; next_pc = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    #1;
    $display("reset released: flags=%b condex=%b", bus0.Flags, bus0.CondEx);

    // Flag write blocked while CondExReg=0
    write_flags(2'b11, 4'b1111);
    check("gated_flagw", bus0.Flags, 4'b0000);

    // 2: EQ taken
    latch(4'b1110);
    check("al_condex", {3'b0, bus0.CondEx}, 4'b0001);
    write_flags(2'b11, 4'b0100);
    check("eq_flags", bus0.Flags, 4'b0100);
    latch(4'b0000);
    check("eq_condex", {3'b0, bus0.CondEx}, 4'b0001);
    pcs = 1'b1; #1;
    check("eq_pcwrite", {3'b0, bus0.PCWrite}, 4'b0001);
    pcs = 1'b0;
    // EQ not taken
    write_flags(2'b11, 4'b0000);
    check("ne_flags", bus0.Flags, 4'b0000);
    latch(4'b0000);
    check("eq0_condex", {3'b0, bus0.CondEx}, 4'b0000);
    pcs = 1'b1; #1;
    check("eq0_pcwrite", {3'b0, bus0.PCWrite}, 4'b0000);
    pcs = 1'b0;
    $display("EQ taken/not-taken done");

    // 3: hold across a later flag update
    latch(4'b1110);
    write_flags(2'b11, 4'b0100);
    latch(4'b0000);
    write_flags(2'b11, 4'b0000);
    check("hold_flags", bus0.Flags, 4'b0000);
    check("hold_condex", {3'b0, bus0.CondEx}, 4'b0001);
    reg_w = 1'b1; #1;
    check("hold_regwrite", {3'b0, bus0.RegWrite}, 4'b0001);
    reg_w = 1'b0;
    $display("hold done");

    // Simultaneous latch + flag write: flags use old CondExReg, new result uses old flags
    latch(4'b0000);  // Z=0 -> CondEx=0
    cond = 4'b0001; cond_latch = 1'b1; flag_w = 2'b11; alu_flags = 4'b0100;
    tick();
    check("sim1_flags", bus0.Flags, 4'b0000);
    check("sim1_condex", {3'b0, bus0.CondEx}, 4'b0001);
    cond = 4'b0000;
    tick();
    cond_latch = 1'b0; flag_w = 2'b00;
    check("sim2_flags", bus0.Flags, 4'b0100);
    check("sim2_condex", {3'b0, bus0.CondEx}, 4'b0000);
    $display("simultaneous latch/flag write done");

    // 4: partial flag writes
    latch(4'b1110);
    write_flags(2'b11, 4'b0011);
    check("part_setup", bus0.Flags, 4'b0011);
    write_flags(2'b10, 4'b1000);
    check("part_nz", bus0.Flags, 4'b1011);
    write_flags(2'b01, 4'b0100);
    check("part_cv", bus0.Flags, 4'b1000);
    $display("partial flag writes done");

    // 5: full sweep, both NV settings
    for (int f = 0; f < 16; f++) begin
      latch(4'b1110);
      write_flags(2'b11, 4'(f));
      check("sweep_flags", bus1.Flags, 4'(f));
      for (int c = 0; c < 16; c++) begin
        latch(4'(c));
        check($sformatf("sweep0_f%0d_c%0d", f, c), {3'b0, bus0.CondEx},
              {3'b0, ref_cond(4'(c), 4'(f), 1'b0)});
        check($sformatf("sweep1_f%0d_c%0d", f, c), {3'b0, bus1.CondEx},
              {3'b0, ref_cond(4'(c), 4'(f), 1'b1)});
      end
      $display("sweep flags=%b done", 4'(f));
    end

    // 6: NoWrite / NextPC / MemWrite gating
    latch(4'b1110);
    reg_w = 1'b1; no_write = 1'b1; #1;
    check("nowrite_reg", {3'b0, bus0.RegWrite}, 4'b0000);
    no_write = 1'b0; #1;
    check("write_reg", {3'b0, bus0.RegWrite}, 4'b0001);
    reg_w = 1'b0;
    latch(4'b1111);
    check("nv0_condex", {3'b0, bus0.CondEx}, 4'b0000);
    check("nv1_condex", {3'b0, bus1.CondEx}, 4'b0001);
    next_pc = 1'b1; #1;
    check("nextpc_ungated", {3'b0, bus0.PCWrite}, 4'b0001);
    next_pc = 1'b0; pcs = 1'b1; #1;
    check("pcs_gated", {3'b0, bus0.PCWrite}, 4'b0000);
    check("pcs_nv1", {3'b0, bus1.PCWrite}, 4'b0001);
    pcs = 1'b0; mem_w = 1'b1; #1;
    check("memw_gated", {3'b0, bus0.MemWrite}, 4'b0000);
    check("memw_nv1", {3'b0, bus1.MemWrite}, 4'b0001);
    $display("strobe gating done");

    // Reset mid-instruction on dut1 (CondEx=1, flags nonzero)
    pcs = 1'b1; reg_w = 1'b1; reset = 1'b1; #1;
    check("midrst_pc", {3'b0, bus1.PCWrite}, 4'b0000);
    check("midrst_reg", {3'b0, bus1.RegWrite}, 4'b0000);
    check("midrst_mem", {3'b0, bus1.MemWrite}, 4'b0000);
    tick();
    check("midrst_flags", bus1.Flags, 4'b0000);
    check("midrst_condex", {3'b0, bus1.CondEx}, 4'b0000);
    reset = 1'b0; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    $display("mid-instruction reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
